trap_ctrl: RTL

Sequences machine-mode trap entry and return around the CSR block. At the commit stage it arbitrates pending interrupts, synchronous exceptions, MRET and WFI, and produces the CSR write bundle: mepc, mcause, mtval, mie/mpie. It also issues a PC redirect to the fetch stage and a retire pulse for minstret. It sits between the commit stage, the CSR block and fetch.

---
 rtl/trap_ctrl_if.sv | 59 +++++
 rtl/trap_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl_if.sv
// Commit / CSR / fetch signal bundle around the machine-mode trap controller.
// The slave modport is the controller's view; master is the surrounding core.
interface trap_ctrl_if;
  // commit stage
  logic        commit_valid;
  logic        commit_ready;
  logic [31:0] commit_pc;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [31:0] exc_tval;
  logic        is_mret;
  logic        is_wfi;

  // CSR state and interrupt lines
  logic        mie;
  logic        mpie;
  logic        mtip;
  logic        msip;
  logic        meip;
  logic        mtie;
  logic        msie;
  logic        meie;
  logic [29:0] mtvec_base;
  logic [31:0] mepc;

  // CSR write bundle
  logic        csr_trap_we;
  logic        csr_status_we;
  logic [31:0] csr_mepc_wd;
  logic [31:0] csr_mcause_wd;
  logic [31:0] csr_mtval_wd;
  logic        csr_mie_wd;
  logic        csr_mpie_wd;

  // fetch redirect and status
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic        retire;
  logic        sleeping;

  modport slave (
    input  commit_valid, commit_pc, exc_valid, exc_code, exc_tval, is_mret, is_wfi,
    input  mie, mpie, mtip, msip, meip, mtie, msie, meie, mtvec_base, mepc,
    input  redirect_ready,
    output commit_ready, csr_trap_we, csr_status_we, csr_mepc_wd, csr_mcause_wd,
    output csr_mtval_wd, csr_mie_wd, csr_mpie_wd, redirect_valid, redirect_pc,
    output retire, sleeping
  );

  modport master (
    output commit_valid, commit_pc, exc_valid, exc_code, exc_tval, is_mret, is_wfi,
    output mie, mpie, mtip, msip, meip, mtie, msie, meie, mtvec_base, mepc,
    output redirect_ready,
    input  commit_ready, csr_trap_we, csr_status_we, csr_mepc_wd, csr_mcause_wd,
    input  csr_mtval_wd, csr_mie_wd, csr_mpie_wd, redirect_valid, redirect_pc,
    input  retire, sleeping
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry/return sequencer between commit, the CSR block and fetch.
// Optional macro TRAP_CTRL_VECTORED_EN: interrupt traps jump to base + 4*cause.
module trap_ctrl #(
  parameter bit WFI_WAKE_ANY = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  trap_ctrl_if.slave tc
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CODEW = 4;

  localparam logic [CODEW-1:0] CODE_MEI = CODEW'(11);
  localparam logic [CODEW-1:0] CODE_MSI = CODEW'(3);
  localparam logic [CODEW-1:0] CODE_MTI = CODEW'(7);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRAP_WR  = 2'd1,
    REDIRECT = 2'd2,
    SLEEP    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   mepc_q, mepc_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   tval_q, tval_d;
  logic [XLEN-1:0]   target_q, target_d;

  logic              irq_pend;
  logic [CODEW-1:0]  irq_code;
  logic              wake;
  logic [XLEN-1:0]   trap_base;
  logic [XLEN-1:0]   trap_target;

  logic              commit_ready_c;
  logic              retire_c;
  logic              status_we_c;
  logic              trap_we_c;
  logic              mie_wd_c;
  logic              mpie_wd_c;
  logic              redirect_valid_c;
  logic              sleeping_c;

  // Interrupt detection and fixed priority MEI > MSI > MTI.
  always_comb begin
    irq_pend = (tc.meip & tc.meie) | (tc.msip & tc.msie) | (tc.mtip & tc.mtie);
    if (tc.meip && tc.meie) begin
      irq_code = CODE_MEI;
    end else if (tc.msip && tc.msie) begin
      irq_code = CODE_MSI;
    end else begin
      irq_code = CODE_MTI;
    end
  end

  assign wake      = WFI_WAKE_ANY ? irq_pend : (tc.mie & irq_pend);
  assign trap_base = {tc.mtvec_base, 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
  // Only interrupts are vectored; exceptions share the base entry.
  assign trap_target = cause_q[XLEN-1]
                     ? trap_base + XLEN'({cause_q[CODEW-1:0], 2'b00})
                     : trap_base;
`else
  assign trap_target = trap_base;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mepc_q   <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      mepc_q   <= mepc_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    mepc_d           = mepc_q;
    cause_d          = cause_q;
    tval_d           = tval_q;
    target_d         = target_q;
    commit_ready_c   = 1'b0;
    retire_c         = 1'b0;
    status_we_c      = 1'b0;
    trap_we_c        = 1'b0;
    mie_wd_c         = 1'b0;
    mpie_wd_c        = 1'b0;
    redirect_valid_c = 1'b0;
    sleeping_c       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tc.commit_valid) begin
          commit_ready_c = 1'b1;
          if (tc.mie && irq_pend) begin
            // Interrupted instruction is flushed and replays after MRET.
            mepc_d  = tc.commit_pc;
            cause_d = {1'b1, 27'b0, irq_code};
            tval_d  = '0;
            state_d = TRAP_WR;
          end else if (tc.exc_valid) begin
            mepc_d  = tc.commit_pc;
            cause_d = {1'b0, 27'b0, tc.exc_code};
            tval_d  = tc.exc_tval;
            state_d = TRAP_WR;
          end else if (tc.is_mret) begin
            status_we_c = 1'b1;
            mie_wd_c    = tc.mpie;
            mpie_wd_c   = 1'b1;
            retire_c    = 1'b1;
            target_d    = tc.mepc;
            state_d     = REDIRECT;
          end else if (tc.is_wfi) begin
            retire_c = 1'b1;
            state_d  = SLEEP;
          end else begin
            retire_c = 1'b1;
          end
        end
      end

      TRAP_WR: begin
        trap_we_c = 1'b1;
        mie_wd_c  = 1'b0;
        mpie_wd_c = tc.mie;
        target_d  = trap_target;
        state_d   = REDIRECT;
      end

      REDIRECT: begin
        redirect_valid_c = 1'b1;
        if (tc.redirect_ready) begin
          state_d = IDLE;
        end
      end

      SLEEP: begin
        sleeping_c = 1'b1;
        if (wake) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Commit-side strobes depend on live inputs; hold them low while reset is asserted.
  assign tc.commit_ready   = commit_ready_c & rst_n;
  assign tc.retire         = retire_c & rst_n;
  assign tc.csr_status_we  = status_we_c & rst_n;
  assign tc.csr_mie_wd     = mie_wd_c & rst_n;
  assign tc.csr_mpie_wd    = mpie_wd_c & rst_n;

  assign tc.csr_trap_we    = trap_we_c;
  assign tc.csr_mepc_wd    = mepc_q;
  assign tc.csr_mcause_wd  = cause_q;
  assign tc.csr_mtval_wd   = tval_q;
  assign tc.redirect_valid = redirect_valid_c;
  assign tc.redirect_pc    = target_q;
  assign tc.sleeping       = sleeping_c;

endmodule
